// File: rtl/cube_pkg.sv
// Shared constants and state type for the integer cube unit.
// Imported by cube and by anything wiring it to the external adder.
package cube_pkg;

    localparam int X_W   = 5;
    localparam int Y_W   = 16;
    localparam int STEPS = 5;
    localparam int S_W   = 3;

    localparam logic [S_W-1:0] LAST_STEP = S_W'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SQ,
        CB
    } state_t;

endpackage

// File: rtl/cube.sv
// Integer cube unit: x^3 by two shift-and-add passes, all adds via external sum.
// Ports: clk, rst (async active-low), x_i, start, result, busy, sum_in_a/b, sum_out.
module cube
    import cube_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic [X_W-1:0] x_i,
    input  logic           start,
    output logic [Y_W-1:0] result,
    output logic           busy,
    output logic [Y_W-1:0] sum_in_a,
    output logic [Y_W-1:0] sum_in_b,
    input  logic [Y_W-1:0] sum_out
);

    state_t         state;
    state_t         state_n;
    logic [X_W-1:0] x_r;
    logic [X_W-1:0] x_n;
    logic [Y_W-1:0] acc;
    logic [Y_W-1:0] acc_n;
    logic [Y_W-1:0] sq;
    logic [Y_W-1:0] sq_n;
    logic [S_W-1:0] step;
    logic [S_W-1:0] step_n;
    logic [Y_W-1:0] result_n;

    logic [7:0]     x_ext;
    logic           bit_on;
    logic [Y_W-1:0] base;
    logic           last;

    assign busy  = (state != IDLE);
    assign x_ext = {{(8 - X_W){1'b0}}, x_r};
    assign last  = (step == LAST_STEP);

    // Shared multiplier datapath: the multiplier is always x_r;
    // the multiplicand is x_r in SQ and the stored square in CB.
    always_comb begin
        sum_in_a = '0;
        sum_in_b = '0;
        base     = '0;
        bit_on   = 1'b0;
        if (state != IDLE) begin
            sum_in_a = acc;
            base     = (state == SQ) ? Y_W'(x_r) : sq;
            bit_on   = x_ext[step];
            sum_in_b = bit_on ? (base << step) : '0;
        end
    end

    always_comb begin
        state_n  = state;
        x_n      = x_r;
        acc_n    = acc;
        sq_n     = sq;
        step_n   = step;
        result_n = result;
        unique case (state)
            IDLE: begin
                if (start) begin
                    x_n     = x_i;
                    acc_n   = '0;
                    step_n  = '0;
                    state_n = SQ;
                end
            end
            SQ: begin
                acc_n = sum_out;
                if (last) begin
                    sq_n    = sum_out;
                    acc_n   = '0;
                    step_n  = '0;
                    state_n = CB;
                end else begin
                    step_n = step + 1'b1;
                end
            end
            CB: begin
                acc_n = sum_out;
                if (last) begin
                    result_n = sum_out;
                    step_n   = '0;
                    state_n  = IDLE;
                end else begin
                    step_n = step + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            x_r    <= '0;
            acc    <= '0;
            sq     <= '0;
            step   <= '0;
            result <= '0;
        end else begin
            state  <= state_n;
            x_r    <= x_n;
            acc    <= acc_n;
            sq     <= sq_n;
            step   <= step_n;
            result <= result_n;
        end
    end

endmodule

// File: tb/tb_cube.sv
// Self-checking bench for cube with a behavioural adder and cube-root model.
// Directed table, random ops, back-to-back sweep, ignore and reset corners.
module tb_cube;
    import cube_pkg::*;

    logic           clk;
    logic           rst;
    logic [X_W-1:0] x_i;
    logic           start;
    logic [Y_W-1:0] result;
    logic           busy;
    logic [Y_W-1:0] sum_in_a;
    logic [Y_W-1:0] sum_in_b;
    logic [Y_W-1:0] sum_out;

    int tests;
    int fails;

    assign sum_out = sum_in_a + sum_in_b;

    cube dut (
        .clk      (clk),
        .rst      (rst),
        .x_i      (x_i),
        .start    (start),
        .result   (result),
        .busy     (busy),
        .sum_in_a (sum_in_a),
        .sum_in_b (sum_in_b),
        .sum_out  (sum_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int ref_cube(input int x);
        return x * x * x;
    endfunction

    function automatic int ref_cbrt(input int y);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= y) r++;
        return r;
    endfunction

    task automatic wait_done(inout int cnt, output bit zero_ok);
        zero_ok = 1'b1;
        while (busy && cnt < 30) begin
            if (sum_in_b != 0) zero_ok = 1'b0;
            @(posedge clk);
            #1;
            cnt++;
        end
    endtask

    task automatic run_op(input int x, input int exp, input string name);
        int cnt;
        bit zok;
        x_i   = X_W'(x);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cnt = 0;
        wait_done(cnt, zok);
        check({name, "_lat"}, cnt, 10);
        check({name, "_res"}, int'(result), exp);
    endtask

    initial begin
        int cnt;
        bit zok;
        tests = 0;
        fails = 0;
        rst   = 1'b0;
        start = 1'b0;
        x_i   = '0;
        vecs[0] = '{1, 1};
        vecs[1] = '{3, 27};
        vecs[2] = '{6, 216};
        vecs[3] = '{17, 4913};
        vecs[4] = '{31, 29791};

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_result", int'(result), 0);
        check("rst_sum_a", int'(sum_in_a), 0);
        check("rst_sum_b", int'(sum_in_b), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // x = 0: no partial product is ever added
        x_i   = '0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cnt = 0;
        wait_done(cnt, zok);
        check("zero_lat", cnt, 10);
        check("zero_res", int'(result), 0);
        check("zero_sum_b", int'(zok), 1);

        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].x, vecs[i].y, $sformatf("dir%0d", vecs[i].x));
        end

        for (int i = 0; i < 16; i++) begin
            int x;
            x = int'($urandom_range(0, 31));
            run_op(x, ref_cube(x), $sformatf("rnd%0d", x));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        // Back-to-back sweep with start held high
        start = 1'b1;
        for (int i = 0; i < 32; i++) begin
            x_i = X_W'(i);
            @(posedge clk);
            #1;
            cnt = 0;
            wait_done(cnt, zok);
            check($sformatf("swp%0d_lat", i), cnt, 10);
            check($sformatf("swp%0d_res", i), int'(result), ref_cube(i));
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        check("swp_stop", int'(busy), 0);

        // start while busy is ignored
        x_i   = 5'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        x_i   = 5'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        x_i   = '0;
        cnt = 3;
        wait_done(cnt, zok);
        check("ign_lat", cnt, 10);
        check("ign_res", int'(result), 125);
        repeat (2) @(posedge clk);
        #1;
        check("ign_norestart", int'(busy), 0);

        // Reset in the middle of an operation
        x_i   = 5'd31;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_busy_pre", int'(busy), 1);
        rst = 1'b0;
        #1;
        check("mid_busy", int'(busy), 0);
        check("mid_res", int'(result), 0);
        check("mid_sum_a", int'(sum_in_a), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_op(4, 64, "after_rst");

        // Round trip through the cube-root model
        for (int i = 0; i <= 6; i++) begin
            run_op(i, ref_cube(i), $sformatf("rt%0d", i));
            check($sformatf("rt%0d_root", i), ref_cbrt(int'(result)), i);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cube.md
# cube

Integer cube unit: latches a 5-bit unsigned operand on `start` and returns its exact 16-bit cube after a fixed number of cycles. It contains no datapath adder. Every addition is routed through the team's external combinational `sum` block over the same three-wire adder interface the cube-root unit uses. It is the forward counterpart of the cube-root block: it generates x³ values, and `cbrt` must invert them.

## Interface
Parameters: none. Widths are fixed by package constants.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  asynchronous reset, active-low (0 = reset)
- `x_i`  in  5  unsigned operand, sampled only on an accepted `start`
- `start`  in  1  request pulse
- `result`  out  16  x³ of the last completed operation
- `busy`  out  1  high while an operation is in progress
- `sum_in_a`  out  16  adder operand A, driven to the external `sum`
- `sum_in_b`  out  16  adder operand B, driven to the external `sum`
- `sum_out`  in  16  external adder result; combinational `sum_in_a + sum_in_b`, mod 2^16

## Operation
- States:
  - IDLE
  - SQ: computes x·x
  - CB: computes sq·x
- Registers:
  - `x_r` (5 bits)
  - `acc` (16 bits)
  - `sq` (16 bits)
  - `step` (3 bits, values 0..4)
  - `result` (16 bits)
- IDLE, `start`=1:
  - latch `x_r` ← `x_i`
  - `acc` ← 0, `step` ← 0
  - `busy` ← 1, go to SQ
- IDLE, `start`=0: no change.
- SQ, each cycle:
  - `sum_in_a` = `acc`
  - `sum_in_b` = `x_r[step]` ? (`x_r` << `step`) : 0
  - `acc` ← `sum_out`
  - at `step`=4: `sq` ← `sum_out`, `acc` ← 0, `step` ← 0, go to CB
  - otherwise `step`++
- CB, each cycle:
  - `sum_in_a` = `acc`
  - `sum_in_b` = `x_r[step]` ? (`sq` << `step`) : 0
  - `acc` ← `sum_out`
  - at `step`=4: `result` ← `sum_out`, `busy` ← 0, go to IDLE
  - otherwise `step`++
- Bit-clear steps still consume one cycle, so latency does not depend on data.
- In IDLE, `sum_in_a` = `sum_in_b` = 0.
- Width rules:
  - max 31³ = 29791 < 2^16, so no overflow is possible
  - shifted operands are zero-extended to 16 bits before shifting
- `start` while `busy`=1 is ignored: no restart and no latch of `x_i`.
- `result` holds its value until the next completion. It is not cleared on `start`.

## Timing
- Reset, asynchronous, `rst`=0: state IDLE, `busy`=0, `result`=0, `acc`=`sq`=`step`=`x_r`=0, `sum_in_a`=`sum_in_b`=0.
- Reset asserted mid-operation aborts immediately. No completion occurs and `result` = 0.
- The edge that samples `start`=1 in IDLE sets `busy`=1 (registered).
- Latency is exactly 10 cycles: 5 SQ + 5 CB. `busy` is high for 10 rising edges after the accepting edge.
- `result` and `busy` fall update on the same edge. `result` is valid whenever `busy`=0.
- `start`=1 held at completion: the IDLE cycle following completion accepts it. Back-to-back issue is therefore 11 cycles per operation.
- `sum_in_*` depend only on registered state (Moore). There is no combinational path from `start` or `x_i` to any output.

## Structure
- Shared package `cube_pkg`:
  - `X_W`=5, `Y_W`=16, `STEPS`=5
  - state enum {IDLE, SQ, CB}
- The adder is the existing external `sum` module and is not instantiated inside `cube`. The bench and top level wire `cube` to `sum`.
- No further sub-module. The two multiply phases share one step/mux datapath selected by state.

## Test plan
- Reset, then `x_i`=0, `start` pulse:
  - `busy` high for exactly 10 cycles
  - `result`=0
  - `sum_in_b`=0 every cycle
- Directed values, each with a 10-cycle count checked:
  - `x_i`=1 → 1
  - 3 → 27
  - 6 → 216
  - 17 → 4913
  - 31 → 29791
- Sweep `x_i`=0..31 back-to-back with `start` held high: each `result` matches x³, with one operation per 11 cycles.
- `x_i`=5 started, then at cycle 3 `start`=1 with `x_i`=2: ignored, `result`=125.
- Reset asserted at cycle 6 of `x_i`=31:
  - `busy`=0 and `result`=0 immediately
  - the next `start` with `x_i`=4 gives 64
- Round trip: for `x_i`=0..6, feed `result` to `cbrt`; the root equals `x_i`.
